uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the clock cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Port CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port RST  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 Port FE  input  1  SHALL be the upstream byte-FIFO empty flag (1 = no byte available).
REQ-005 Port DI  input  8  SHALL be the upstream FIFO registered read data, valid the cycle after an RREQ edge.
REQ-006 Port RREQ  output  1  SHALL be the read request to the upstream FIFO, one-cycle pulse per byte.
REQ-007 Port TX  output  1  SHALL be the serial line, idle high, registered.
REQ-008 Port BUSY  output  1  SHALL be 1 in every state except IDLE.

Function
REQ-009 FSM states SHALL be IDLE, REQ, LATCH, START, DATA, STOP.
REQ-010 IDLE: FE=0 sampled -> REQ next cycle; FE=1 -> stay IDLE; RREQ SHALL never assert while in IDLE.
REQ-011 REQ: RREQ=1 for exactly this one cycle; unconditional -> LATCH.
REQ-012 LATCH: DI captured into 8-bit shift register, bit index cleared to 0, baud counter cleared; -> START.
REQ-013 START: TX=0 for exactly CLKS_PER_BIT cycles; -> DATA.
REQ-014 DATA: TX = shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shift right after each bit; after bit index 7 completes -> STOP.
REQ-015 STOP: TX=1 for exactly CLKS_PER_BIT cycles; -> IDLE.
REQ-016 TX SHALL be 1 in IDLE, REQ and LATCH.
REQ-017 Frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle, 8N1, no parity.
REQ-018 Back-to-back: with FE=0 continuously, line-high gap between frames SHALL be CLKS_PER_BIT + 3 cycles (stop bit plus IDLE, REQ, LATCH); no other idle cycles.
REQ-019 Latency: FE falling sampled in IDLE at edge N -> RREQ high during cycle N+1 -> TX falls at edge N+3.
REQ-020 Baud counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits, counting 0..CLKS_PER_BIT-1 and wrapping to 0 at the bit boundary; bit index 3 bits, no overflow past 7.
REQ-021 FE changes outside IDLE SHALL be ignored; a byte written upstream mid-frame is fetched only on return to IDLE.
REQ-022 DI SHALL be sampled only in LATCH; DI changes at other times SHALL not alter the frame in flight.
REQ-023 Upstream FIFO empty/stale reads are not possible: RREQ issues only after FE=0 was sampled.

Reset
REQ-024 RST=1 SHALL immediately force state IDLE, TX=1, RREQ=0, BUSY=0, baud counter 0, bit index 0, shift register 0x00.
REQ-025 Reset mid-frame SHALL abort the frame (TX high at once); the byte already popped is lost, no retry.
REQ-026 After RST deasserts, the first possible RREQ SHALL be the cycle after the first edge that samples FE=0.

Structure
REQ-027 State encoding (3-bit localparams) and default CLKS_PER_BIT SHALL live in a shared uart package/include used by this block and the future uart_rx.
REQ-028 One sub-module, baud_counter (inputs CLK, RST, clear; output bit_done pulse), SHALL generate the per-bit strobe; everything else stays in uart_tx.
REQ-029 TX, RREQ and BUSY SHALL be registered or decoded from registered state only; no combinational path from FE or DI to any output.

Verification (bench CLKS_PER_BIT=4, upstream FIFO instantiated)
REQ-030 Reset idle: RST pulse, FE=1 for 100 cycles -> TX=1, RREQ=0, BUSY=0 throughout.
REQ-031 Single byte: write 0xA5 -> exactly one RREQ pulse; TX = 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles); FE=1 afterwards.
REQ-032 Back-to-back: write 0x00,0xFF,0x55 -> three frames decoded in order, line-high gap 7 cycles between frames, three RREQ pulses total.
REQ-033 Reset mid-frame: write 0x3C, assert RST during DATA bit 3 -> TX=1 same cycle; after release with FE=1 no further activity; 0x3C never completes.
REQ-034 Late write: write 0x81 during STOP of a preceding frame -> 0x81 sent as the next frame with the REQ-018 gap, not earlier.
REQ-035 Latency: FE falls at edge N in IDLE -> RREQ high in cycle N+1, TX falls at edge N+3 (checked by assertion).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state encoding shared by uart_tx and the future uart_rx.
// Contents: CLKS_PER_BIT_DEF (115200 baud at 100 MHz), 3-bit state localparams, and the state_t enum built on them.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    REQ   = S_REQ,
    LATCH = S_LATCH,
    START = S_START,
    DATA  = S_DATA,
    STOP  = S_STOP
  } state_t;
endpackage

// File: rtl/baud_counter.sv
// baud_counter: per-bit strobe generator; counts 0..CLKS_PER_BIT-1 and wraps at the bit boundary.
// Ports: CLK clock, RST async active-high reset, clear holds the count at 0, bit_done pulses on the last cycle of each bit.
module baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] r_cnt;
  assign bit_done = r_cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_cnt <= '0;
    else r_cnt <= (clear || bit_done) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter that pops bytes from an upstream FIFO with registered read data.
// Ports: CLK clock, RST async active-high reset, FE FIFO empty, DI FIFO read data,
//        RREQ one-cycle FIFO read pulse, TX serial line (idle high), BUSY high outside IDLE.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FE,
  input  logic [7:0] DI,
  output logic       RREQ,
  output logic       TX,
  output logic       BUSY
);
  state_t     r_state, w_next;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic       r_tx;
  logic       w_bit_done;
  logic       w_clear;
  // The counter only runs while a bit is on the line, so START always begins at count 0.
  assign w_clear = !(r_state inside {START, DATA, STOP});
  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (w_clear),
    .bit_done (w_bit_done)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = FE ? IDLE : REQ;
      REQ:     w_next = LATCH;
      LATCH:   w_next = START;
      START:   w_next = w_bit_done ? DATA : START;
      DATA:    w_next = (w_bit_done && r_bit == 3'd7) ? STOP : DATA;
      STOP:    w_next = w_bit_done ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // TX is registered from the current state, so the line trails the state by one cycle uniformly.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_tx <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
      if (r_state == LATCH) begin
        r_shift <= DI;
        r_bit   <= '0;
      end else if (r_state == DATA && w_bit_done) begin
        r_shift <= r_shift >> 1;
        r_bit   <= (r_bit == 3'd7) ? r_bit : r_bit + 1'b1;
      end
    end
  assign TX   = r_tx;
  assign RREQ = r_state == REQ;
  assign BUSY = r_state != IDLE;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4 and a small upstream FIFO model.
module tb_uart_tx;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       FE;
  logic [7:0] DI = 8'h00;
  logic       RREQ, TX, BUSY;
  logic [7:0] mem [16];
  logic [3:0] wp = '0;
  logic [3:0] rp = '0;
  int n_checks = 0;
  int n_errors = 0;
  int n_rreq = 0;
  int r0;
  int bad;
  uart_tx #(.CLKS_PER_BIT(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .FE   (FE),
    .DI   (DI),
    .RREQ (RREQ),
    .TX   (TX),
    .BUSY (BUSY)
  );
  always #5 CLK = ~CLK;
  assign FE = (wp == rp);
  always @(posedge CLK)
    if (RREQ) begin
      DI <= mem[rp];
      rp <= rp + 4'd1;
    end
  always @(negedge CLK)
    if (RREQ) n_rreq++;
  task automatic tick();
    @(negedge CLK);
  endtask
  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 4'd1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Waits for the start bit counting high samples, then checks all 40 line samples of the frame.
  task automatic frame(input logic [7:0] b, input int gap_exp, input bit late, input logic [7:0] lb, input string tag);
    int cnt;
    logic [9:0] f;
    cnt = 0;
    f = {1'b1, b, 1'b0};
    tick();
    while (TX !== 1'b0 && cnt < 200) begin
      cnt++;
      tick();
    end
    chk({tag, " gap"}, cnt, gap_exp);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      chk($sformatf("%s bit%0d", tag, k / 4), {31'd0, TX}, {31'd0, f[k/4]});
      if (late && k == 37) push(lb);
    end
  endtask
  initial begin
    repeat (3) tick();
    chk("rst tx", {31'd0, TX}, 32'd1);
    chk("rst rreq", {31'd0, RREQ}, 32'd0);
    chk("rst busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (TX !== 1'b1 || RREQ !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    chk("idle quiet", bad, 0);
    r0 = n_rreq;
    push(8'hA5);
    tick();
    chk("lat rreq", {31'd0, RREQ}, 32'd1);
    chk("lat busy", {31'd0, BUSY}, 32'd1);
    chk("lat tx", {31'd0, TX}, 32'd1);
    frame(8'hA5, 2, 1'b0, 8'h00, "a5");
    repeat (2) tick();
    chk("a5 rreq count", n_rreq - r0, 1);
    chk("a5 fe", {31'd0, FE}, 32'd1);
    chk("a5 busy end", {31'd0, BUSY}, 32'd0);
    chk("a5 tx end", {31'd0, TX}, 32'd1);
    r0 = n_rreq;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    frame(8'h00, 3, 1'b0, 8'h00, "b00");
    frame(8'hFF, 3, 1'b0, 8'h00, "bff");
    frame(8'h55, 3, 1'b0, 8'h00, "b55");
    repeat (3) tick();
    chk("b2b rreq count", n_rreq - r0, 3);
    chk("b2b fe", {31'd0, FE}, 32'd1);
    chk("b2b busy end", {31'd0, BUSY}, 32'd0);
    r0 = n_rreq;
    push(8'h3C);
    bad = 0;
    tick();
    while (TX !== 1'b0 && bad < 200) begin
      bad++;
      tick();
    end
    chk("3c gap", bad, 3);
    repeat (17) tick();
    chk("3c mid busy", {31'd0, BUSY}, 32'd1);
    RST = 1'b1;
    #1;
    chk("3c rst tx", {31'd0, TX}, 32'd1);
    chk("3c rst busy", {31'd0, BUSY}, 32'd0);
    chk("3c rst rreq", {31'd0, RREQ}, 32'd0);
    repeat (3) tick();
    RST = 1'b0;
    bad = 0;
    repeat (50) begin
      tick();
      if (TX !== 1'b1 || RREQ !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    chk("3c quiet after", bad, 0);
    chk("3c rreq count", n_rreq - r0, 1);
    r0 = n_rreq;
    push(8'h12);
    frame(8'h12, 3, 1'b1, 8'h81, "p12");
    frame(8'h81, 3, 1'b0, 8'h00, "l81");
    repeat (3) tick();
    chk("late rreq count", n_rreq - r0, 2);
    chk("late busy end", {31'd0, BUSY}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
